// File: rtl/dfir_decimate_mc_pkg.sv
// Shared definitions for the multi-channel decimator: config word layout,
// config FSM states and averaging mode codes.
package dfir_decimate_mc_pkg;

  localparam int unsigned CfgDcefLsb  = 0;
  localparam int unsigned CfgPhaseLsb = 8;
  localparam int unsigned CfgShiftLsb = 16;
  localparam int unsigned CfgModeBit  = 20;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StDone = 2'd2,
    StRun  = 2'd3
  } cfg_state_e;

  typedef enum logic {
    ModePick = 1'b0,
    ModeAvg  = 1'b1
  } mode_e;

endpackage

// File: rtl/dfir_dec_sat.sv
// Arithmetic right shift of a wide signed sum followed by saturation to a
// narrower signed width.
module dfir_dec_sat #(
  parameter int unsigned InWidth  = 32,
  parameter int unsigned OutWidth = 24
) (
  input  logic signed [InWidth-1:0]  sum_i,
  input  logic        [3:0]          shift_i,
  output logic        [OutWidth-1:0] data_o
);

  logic signed [InWidth-1:0] shifted;
  logic                      fits;

  always_comb begin
    shifted = sum_i >>> shift_i;
    // Fits when every bit above the output sign bit replicates the sign.
    fits    = (shifted[InWidth-1:OutWidth-1] ==
               {(InWidth-OutWidth+1){shifted[InWidth-1]}});
    data_o  = fits ? shifted[OutWidth-1:0]
                   : {shifted[InWidth-1], {(OutWidth-1){~shifted[InWidth-1]}}};
  end

endmodule

// File: rtl/dfir_decimate_mc.sv
// Multi-channel decimator with pick/average modes and a small config FSM;
// every emit is registered with one cycle of latency.
module dfir_decimate_mc
  import dfir_decimate_mc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH             = 24,
  parameter int unsigned DFIR_MAX_CHANNELS      = 4,
  parameter int unsigned DCEF_WIDTH             = 8,
  parameter int unsigned DFIR_CONFIG_DATA_WIDTH = 24,
  parameter int unsigned DFIR_DCEF_DEFAULT      = 5
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic                              isConfig,
  input  logic [DFIR_CONFIG_DATA_WIDTH-1:0] Data_Config_In,
  output logic                              isConfigDone,
  input  logic [DATA_WIDTH-1:0]             Data_In,
  input  logic                              Data_In_Valid,
  input  logic [3:0]                        Data_In_ChIdx,
  output logic [DATA_WIDTH-1:0]             Data_Out,
  output logic                              Data_Out_Valid,
  output logic [3:0]                        Data_Out_ChIdx,
  output logic                              Ch_Err
);

  localparam int unsigned AccWidth = DATA_WIDTH + DCEF_WIDTH;
  localparam int unsigned ChW      = (DFIR_MAX_CHANNELS > 1) ? $clog2(DFIR_MAX_CHANNELS) : 1;

  cfg_state_e             state_q, state_d;
  logic [DCEF_WIDTH-1:0]  dcef_q, dcef_d;
  logic [7:0]             phase_q, phase_d;
  logic [3:0]             shift_q, shift_d;
  mode_e                  mode_q, mode_d;
  logic [DCEF_WIDTH-1:0]  cnt_q [DFIR_MAX_CHANNELS];
  logic [DCEF_WIDTH-1:0]  cnt_d [DFIR_MAX_CHANNELS];
  logic signed [AccWidth-1:0] acc_q [DFIR_MAX_CHANNELS];
  logic signed [AccWidth-1:0] acc_d [DFIR_MAX_CHANNELS];
  logic [DATA_WIDTH-1:0]  dout_q, dout_d;
  logic [3:0]             dch_q, dch_d;
  logic                   dvalid_q, dvalid_d;
  logic                   ch_err_q, ch_err_d;

  logic [DCEF_WIDTH-1:0]  cfg_dcef, cfg_eff, cfg_phase_mod, eff_dcef;
  logic [ChW-1:0]         ch_idx;
  logic                   in_range, sample_ok;
  logic signed [AccWidth-1:0] sum;
  logic [DATA_WIDTH-1:0]  sat_out;
  logic                   cfg_unused;

  // Reserved config bits and the stored PHASE are never read back.
  assign cfg_unused = ^{Data_Config_In, phase_q};

  assign cfg_dcef      = DCEF_WIDTH'(Data_Config_In[CfgDcefLsb +: 8]);
  assign cfg_eff       = (cfg_dcef == '0) ? DCEF_WIDTH'(1) : cfg_dcef;
  assign cfg_phase_mod = DCEF_WIDTH'(Data_Config_In[CfgPhaseLsb +: 8]) % cfg_eff;
  assign eff_dcef      = (dcef_q == '0) ? DCEF_WIDTH'(1) : dcef_q;

  assign ch_idx    = ChW'(Data_In_ChIdx);
  assign in_range  = ({28'd0, Data_In_ChIdx} < DFIR_MAX_CHANNELS);
  assign sample_ok = Data_In_Valid && ((state_q == StIdle) || (state_q == StRun));
  assign sum       = acc_q[ch_idx] + $signed({{DCEF_WIDTH{Data_In[DATA_WIDTH-1]}}, Data_In});

  dfir_dec_sat #(
    .InWidth  (AccWidth),
    .OutWidth (DATA_WIDTH)
  ) u_sat (
    .sum_i   (sum),
    .shift_i (shift_q),
    .data_o  (sat_out)
  );

  always_comb begin
    state_d  = state_q;
    dcef_d   = dcef_q;
    phase_d  = phase_q;
    shift_d  = shift_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    dout_d   = dout_q;
    dch_d    = dch_q;
    dvalid_d = 1'b0;
    ch_err_d = 1'b0;

    unique case (state_q)
      StIdle, StRun: if (isConfig) state_d = StLoad;
      StLoad: begin
        dcef_d  = cfg_dcef;
        phase_d = Data_Config_In[CfgPhaseLsb +: 8];
        shift_d = Data_Config_In[CfgShiftLsb +: 4];
        mode_d  = mode_e'(Data_Config_In[CfgModeBit]);
        for (int i = 0; i < DFIR_MAX_CHANNELS; i++) begin
          cnt_d[i] = cfg_phase_mod;
          acc_d[i] = '0;
        end
        state_d = StDone;
      end
      StDone:  state_d = StRun;
      default: state_d = StIdle;
    endcase

    // Samples only flow in IDLE/RUN, so they never collide with the LOAD writes.
    if (sample_ok) begin
      if (!in_range) begin
        ch_err_d = 1'b1;
      end else if (cnt_q[ch_idx] == eff_dcef - DCEF_WIDTH'(1)) begin
        cnt_d[ch_idx] = '0;
        dvalid_d      = 1'b1;
        dch_d         = Data_In_ChIdx;
        if (mode_q == ModeAvg) begin
          dout_d        = sat_out;
          acc_d[ch_idx] = '0;
        end else begin
          dout_d = Data_In;
        end
      end else begin
        cnt_d[ch_idx] = cnt_q[ch_idx] + DCEF_WIDTH'(1);
        if (mode_q == ModeAvg) acc_d[ch_idx] = sum;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= StIdle;
      dcef_q   <= DCEF_WIDTH'(DFIR_DCEF_DEFAULT);
      phase_q  <= '0;
      shift_q  <= '0;
      mode_q   <= ModePick;
      for (int i = 0; i < DFIR_MAX_CHANNELS; i++) begin
        cnt_q[i] <= '0;
        acc_q[i] <= '0;
      end
      dout_q   <= '0;
      dch_q    <= '0;
      dvalid_q <= 1'b0;
      ch_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dcef_q   <= dcef_d;
      phase_q  <= phase_d;
      shift_q  <= shift_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      dout_q   <= dout_d;
      dch_q    <= dch_d;
      dvalid_q <= dvalid_d;
      ch_err_q <= ch_err_d;
    end
  end

  assign isConfigDone   = (state_q == StDone);
  assign Data_Out       = dout_q;
  assign Data_Out_ChIdx = dch_q;
  assign Data_Out_Valid = dvalid_q;
  assign Ch_Err         = ch_err_q;

endmodule

// File: tb/tb_dfir_decimate_mc.sv
// Self-checking bench for dfir_decimate_mc: table-driven stimulus with a
// scoreboard of expected emits, plus hand-written config/error/reset sequences.
module tb_dfir_decimate_mc;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        isConfig = 1'b0;
  logic [23:0] Data_Config_In = '0;
  logic        isConfigDone;
  logic [23:0] Data_In = '0;
  logic        Data_In_Valid = 1'b0;
  logic [3:0]  Data_In_ChIdx = '0;
  logic [23:0] Data_Out;
  logic        Data_Out_Valid;
  logic [3:0]  Data_Out_ChIdx;
  logic        Ch_Err;

  dfir_decimate_mc dut (
    .CLK            (CLK),
    .RST            (RST),
    .isConfig       (isConfig),
    .Data_Config_In (Data_Config_In),
    .isConfigDone   (isConfigDone),
    .Data_In        (Data_In),
    .Data_In_Valid  (Data_In_Valid),
    .Data_In_ChIdx  (Data_In_ChIdx),
    .Data_Out       (Data_Out),
    .Data_Out_Valid (Data_Out_Valid),
    .Data_Out_ChIdx (Data_Out_ChIdx),
    .Ch_Err         (Ch_Err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          cfg;
    logic [23:0] word;
    bit          valid;
    logic [3:0]  ch;
    logic [23:0] data;
    bit          emit;
    logic [23:0] exp;
  } vec_t;

  typedef struct {
    int          cyc;
    logic [3:0]  ch;
    logic [23:0] data;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   cyc   = 0;
  int   nchk  = 0;
  int   npass = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    nchk++;
    if (got === want) npass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, want, cyc);
  endtask

  // Output monitor: every Data_Out_Valid pulse must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      cyc++;
      #1;
      if (Data_Out_Valid === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", {8'd0, Data_Out}, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("out_data", {8'd0, Data_Out}, {8'd0, e.data});
          chk("out_ch", {28'd0, Data_Out_ChIdx}, {28'd0, e.ch});
          chk("out_latency", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic vec_t row_cfg(input logic [23:0] w);
    vec_t r = '{cfg: 1'b1, word: w, valid: 1'b0, ch: 4'd0, data: 24'd0, emit: 1'b0, exp: 24'd0};
    return r;
  endfunction

  function automatic vec_t row_smp(input logic [3:0] ch, input logic [23:0] d,
                                   input bit emit, input logic [23:0] exp);
    vec_t r = '{cfg: 1'b0, word: 24'd0, valid: 1'b1, ch: ch, data: d, emit: emit, exp: exp};
    return r;
  endfunction

  task automatic send(input logic [3:0] ch, input logic [23:0] d, input bit emit,
                      input logic [23:0] exp);
    exp_t e;
    @(negedge CLK);
    Data_In_Valid = 1'b1;
    Data_In_ChIdx = ch;
    Data_In       = d;
    if (emit) begin
      e = '{cyc: cyc + 1, ch: ch, data: exp};
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      Data_In_Valid = 1'b0;
    end
  endtask

  // Config handshake; throws a bad-channel sample at LOAD and a ch1 sample at
  // DONE, both of which must vanish without effect.
  task automatic configure(input logic [23:0] w);
    @(negedge CLK);
    Data_In_Valid  = 1'b0;
    isConfig       = 1'b1;
    Data_Config_In = w;
    @(posedge CLK); #1;
    chk("cfg_done_in_load", {31'd0, isConfigDone}, 32'd0);
    @(negedge CLK);
    isConfig      = 1'b0;
    Data_In_Valid = 1'b1;
    Data_In_ChIdx = 4'd15;
    Data_In       = 24'd77;
    @(posedge CLK); #1;
    chk("cfg_done_pulse", {31'd0, isConfigDone}, 32'd1);
    chk("cfg_load_drop_noerr", {31'd0, Ch_Err}, 32'd0);
    @(negedge CLK);
    Data_In_ChIdx = 4'd1;
    Data_In       = 24'd1000;
    @(posedge CLK); #1;
    chk("cfg_done_clear", {31'd0, isConfigDone}, 32'd0);
    @(negedge CLK);
    Data_In_Valid = 1'b0;
  endtask

  initial begin
    // Default DCEF=5 pick: ch0 1..10 -> 5, 10.
    for (int i = 1; i <= 10; i++) tbl.push_back(row_smp(4'd0, 24'(i), (i % 5) == 0, 24'(i)));
    // DCEF=4 avg SHIFT=2: ch1 4,8,12,16 -> 40>>>2 = 10.
    tbl.push_back(row_cfg(24'h120004));
    tbl.push_back(row_smp(4'd1, 24'd4, 1'b0, 24'd0));
    tbl.push_back(row_smp(4'd1, 24'd8, 1'b0, 24'd0));
    tbl.push_back(row_smp(4'd1, 24'd12, 1'b0, 24'd0));
    tbl.push_back(row_smp(4'd1, 24'd16, 1'b1, 24'd10));
    // DCEF=2 avg SHIFT=0: saturation at both rails.
    tbl.push_back(row_cfg(24'h100002));
    tbl.push_back(row_smp(4'd0, 24'h7FFFFF, 1'b0, 24'd0));
    tbl.push_back(row_smp(4'd0, 24'h7FFFFF, 1'b1, 24'h7FFFFF));
    tbl.push_back(row_smp(4'd2, 24'h800000, 1'b0, 24'd0));
    tbl.push_back(row_smp(4'd2, 24'h800000, 1'b1, 24'h800000));
    // DCEF=3 PHASE=2 pick: ch0/ch1 interleaved, emit on 1st, 4th, 7th sample.
    tbl.push_back(row_cfg(24'h000203));
    for (int i = 0; i < 7; i++) begin
      tbl.push_back(row_smp(4'd0, 24'(10 + i), (i % 3) == 0, 24'(10 + i)));
      tbl.push_back(row_smp(4'd1, 24'(20 + i), (i % 3) == 0, 24'(20 + i)));
    end

    @(posedge CLK); #1;
    chk("rst_out", {8'd0, Data_Out}, 32'd0);
    chk("rst_valid", {31'd0, Data_Out_Valid}, 32'd0);
    chk("rst_ch", {28'd0, Data_Out_ChIdx}, 32'd0);
    chk("rst_cfgdone", {31'd0, isConfigDone}, 32'd0);
    chk("rst_cherr", {31'd0, Ch_Err}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;

    foreach (tbl[i]) begin
      if (tbl[i].cfg) configure(tbl[i].word);
      else if (tbl[i].valid) send(tbl[i].ch, tbl[i].data, tbl[i].emit, tbl[i].exp);
      else idle(1);
    end
    idle(3);
    chk("sb_empty_tbl", sb.size(), 0);
    chk("hold_data", {8'd0, Data_Out}, 32'd26);
    chk("hold_ch", {28'd0, Data_Out_ChIdx}, 32'd1);

    // Out-of-range channels, including the first one past the limit.
    for (int k = 0; k < 2; k++) begin
      send((k == 0) ? 4'd15 : 4'd4, 24'd55, 1'b0, 24'd0);
      @(negedge CLK);
      Data_In_Valid = 1'b0;
      #4;
      chk("cherr_pulse", {31'd0, Ch_Err}, 32'd1);
      @(posedge CLK); #1;
      chk("cherr_clear", {31'd0, Ch_Err}, 32'd0);
    end

    // Reset after 2 of 5 samples: group discarded, outputs cleared.
    configure(24'h000005);
    send(4'd0, 24'd1, 1'b0, 24'd0);
    send(4'd0, 24'd2, 1'b0, 24'd0);
    @(negedge CLK);
    Data_In_Valid = 1'b0;
    #2 RST = 1'b1;
    #1;
    chk("midrst_out", {8'd0, Data_Out}, 32'd0);
    chk("midrst_ch", {28'd0, Data_Out_ChIdx}, 32'd0);
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 1; i <= 5; i++) send(4'd0, 24'(i), i == 5, 24'(i));
    idle(3);
    chk("sb_empty_end", sb.size(), 0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
